// File: rtl/sram_controller.sv
// Responder for the 32-bit memory request port.
// Each word access becomes two 16-bit async SRAM phases, low half first.
module sram_controller #(
  parameter int ADDR_W        = 24,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ack,
  output logic              ready,
  output logic [ADDR_W-1:0] sram_a,
  output logic [15:0]       sram_dq_o,
  output logic              sram_dq_oe,
  input  logic [15:0]       sram_dq_i,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_ub_n,
  output logic              sram_lb_n
);

  localparam int CW = $clog2(ACCESS_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LO,
    S_HI,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_nstate;
  logic [CW-1:0]      r_cnt;
  logic [CW-1:0]      w_ncnt;

  logic               r_we;
  logic [ADDR_W-2:0]  r_ahi;
  logic [31:0]        r_wdata;
  logic [15:0]        r_lo;

  logic [31:0]        r_rdata;
  logic               r_ack;
  logic               r_ready;
  logic [ADDR_W-1:0]  r_a;
  logic [15:0]        r_dq_o;
  logic               r_dq_oe;
  logic               r_ce_n;
  logic               r_oe_n;
  logic               r_we_n;

  logic               w_accept;
  logic               w_last;
  logic               w_we;
  logic [ADDR_W-2:0]  w_ahi;
  logic [31:0]        w_wdata;
  logic               w_act;
  logic               w_hi;

  assign w_accept = (r_state == S_IDLE) && req;
  assign w_last   = (r_cnt == LAST);

  always_comb begin
    w_nstate = r_state;
    w_ncnt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (req) begin
          w_nstate = S_LO;
          w_ncnt   = '0;
        end
      end
      S_LO: begin
        if (w_last) begin
          w_nstate = S_HI;
          w_ncnt   = '0;
        end else begin
          w_ncnt = r_cnt + 1'b1;
        end
      end
      S_HI: begin
        if (w_last) begin
          w_nstate = S_DONE;
          w_ncnt   = '0;
        end else begin
          w_ncnt = r_cnt + 1'b1;
        end
      end
      S_DONE: begin
        w_nstate = S_IDLE;
        w_ncnt   = '0;
      end
      default: begin
        w_nstate = S_IDLE;
        w_ncnt   = '0;
      end
    endcase
  end

  // Pins are registered from next-state, so the accept cycle uses live inputs
  assign w_we    = w_accept ? we : r_we;
  assign w_ahi   = w_accept ? addr[ADDR_W-1:1] : r_ahi;
  assign w_wdata = w_accept ? wdata : r_wdata;
  assign w_act   = (w_nstate == S_LO) || (w_nstate == S_HI);
  assign w_hi    = (w_nstate == S_HI);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_ahi   <= '0;
      r_wdata <= '0;
      r_lo    <= '0;
      r_rdata <= '0;
      r_ack   <= 1'b0;
      r_ready <= 1'b1;
      r_a     <= '0;
      r_dq_o  <= '0;
      r_dq_oe <= 1'b0;
      r_ce_n  <= 1'b1;
      r_oe_n  <= 1'b1;
      r_we_n  <= 1'b1;
    end else begin
      r_state <= w_nstate;
      r_cnt   <= w_ncnt;
      if (w_accept) begin
        r_we    <= we;
        r_ahi   <= addr[ADDR_W-1:1];
        r_wdata <= wdata;
      end
      r_ack   <= (w_nstate == S_DONE);
      r_ready <= (w_nstate == S_IDLE);
      r_ce_n  <= !w_act;
      r_oe_n  <= !(w_act && !w_we);
      r_dq_oe <= w_act && w_we;
      // Last cycle of each phase releases we_n for address/data hold
      r_we_n  <= !(w_act && w_we && (w_ncnt != LAST));
      if (w_act) begin
        r_a <= {w_ahi, w_hi};
      end
      if (w_act && w_we) begin
        r_dq_o <= w_hi ? w_wdata[31:16] : w_wdata[15:0];
      end
      if ((r_state == S_LO) && w_last) begin
        r_lo <= sram_dq_i;
      end
      if ((r_state == S_HI) && w_last && !r_we) begin
        r_rdata <= {sram_dq_i, r_lo};
      end
    end
  end

  assign rdata      = r_rdata;
  assign ack        = r_ack;
  assign ready      = r_ready;
  assign sram_a     = r_a;
  assign sram_dq_o  = r_dq_o;
  assign sram_dq_oe = r_dq_oe;
  assign sram_ce_n  = r_ce_n;
  assign sram_oe_n  = r_oe_n;
  assign sram_we_n  = r_we_n;
  assign sram_ub_n  = 1'b0;
  assign sram_lb_n  = 1'b0;

endmodule
